multicycle_ctrl: RTL

Multi-cycle sequencer for the reduced RISC-V core. It fetches one instruction at a time over a request/acknowledge handshake and latches it into an instruction register. It then steps the shared datapath (register file, ALU, immediate extender, PC) through decode, execute and write-back, driving the same control signals the single-cycle decoder produces. It replaces per-instruction combinational control with a Moore FSM, so the datapath's memory and register file can be multi-cycle.

---
 rtl/multicycle_ctrl_pkg.sv | 29 ++
 rtl/multicycle_ctrl_if.sv | 9 +
 rtl/multicycle_ctrl_instr_decode.sv | 24 ++
 rtl/multicycle_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and instruction constants for the multi-cycle RISC-V sequencer.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } ctrl_state_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_ADDI   = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;

    typedef struct packed {
        logic imem_req;
        logic reg_write;
        logic alu_ctrl;
        logic alu_src;
        logic imm_src;
        logic pc_src;
        logic pc_en;
        logic illegal;
    } ctrl_sigs_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-fetch request/acknowledge handshake between sequencer and imem.
interface multicycle_ctrl_if #(parameter int XLEN = 32);
    logic            imem_req;
    logic            imem_ack;
    logic [XLEN-1:0] instr_rdata;

    modport master (output imem_req, input imem_ack, input instr_rdata);
    modport slave  (input imem_req, output imem_ack, output instr_rdata);
endinterface

// File: rtl/multicycle_ctrl_instr_decode.sv
// Combinational instruction classification plus the static ALU/immediate controls.
module instr_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output logic       is_addi,
    output logic       is_bne,
    output logic       is_unsupported,
    output logic       alu_ctrl,
    output logic       alu_src,
    output logic       imm_src
);

    always_comb begin
        is_addi        = (opcode == OP_IMM)    && (funct3 == F3_ADDI);
        is_bne         = (opcode == OP_BRANCH) && (funct3 == F3_BNE);
        is_unsupported = !(is_addi || is_bne);
        alu_ctrl       = is_bne;
        alu_src        = is_addi;
        imm_src        = is_addi;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-FSM sequencer: fetch over the imem handshake, then decode/execute/write-back.
// Build option MULTICYCLE_ILLEGAL_TRAP_EN: unsupported instructions halt in S_HALT.
//
// state    | meaning
// S_IDLE   | after reset, all controls low
// S_FETCH  | imem_req high, latch ir on imem_ack
// S_DECODE | ALU/immediate controls settle for the decoded type
// S_EXEC   | ALU operation; BNE/NOP retire here with pc_en
// S_WB     | ADDI register write and PC advance
// S_HALT   | unsupported instruction trapped, only rst leaves
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int XLEN = 32
)
(
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master imem,
    input  logic              EQ,
    output logic [XLEN-1:0]   ir,
    output logic              RegWrite,
    output logic              ALUctrl,
    output logic              ALUsrc,
    output logic              ImmSrc,
    output logic              PCsrc,
    output logic              pc_en,
    output logic              illegal,
    output logic [XLEN-1:0]   retire_cnt
);

    ctrl_state_e state;
    ctrl_state_e state_nxt;
    ctrl_sigs_t  ctrl;
    logic        is_addi;
    logic        is_bne;
    logic        is_unsupported;
    logic        dec_alu_ctrl;
    logic        dec_alu_src;
    logic        dec_imm_src;
    logic        retire_evt;

    instr_decode u_decode (
        .opcode         (ir[6:0]),
        .funct3         (ir[14:12]),
        .is_addi        (is_addi),
        .is_bne         (is_bne),
        .is_unsupported (is_unsupported),
        .alu_ctrl       (dec_alu_ctrl),
        .alu_src        (dec_alu_src),
        .imm_src        (dec_imm_src)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH:  if (imem.imem_ack) state_nxt = S_DECODE;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            S_DECODE: state_nxt = is_unsupported ? S_HALT : S_EXEC;
`else
            S_DECODE: state_nxt = S_EXEC;
`endif
            S_EXEC:   state_nxt = is_addi ? S_WB : S_FETCH;
            S_WB:     state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // PCsrc in BNE execute is the only output that looks at a live input (EQ).
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: ctrl.imem_req = 1'b1;
            S_DECODE: begin
                ctrl.alu_ctrl = dec_alu_ctrl;
                ctrl.alu_src  = dec_alu_src;
                ctrl.imm_src  = dec_imm_src;
            end
            S_EXEC: begin
                ctrl.alu_ctrl = dec_alu_ctrl;
                ctrl.alu_src  = dec_alu_src;
                ctrl.imm_src  = dec_imm_src;
                if (is_bne) begin
                    ctrl.pc_en  = 1'b1;
                    ctrl.pc_src = ~EQ;
                end else if (is_unsupported) begin
                    ctrl.pc_en  = 1'b1;
                end
            end
            S_WB: begin
                ctrl.alu_ctrl  = dec_alu_ctrl;
                ctrl.alu_src   = dec_alu_src;
                ctrl.imm_src   = dec_imm_src;
                ctrl.reg_write = 1'b1;
                ctrl.pc_en     = 1'b1;
            end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            S_HALT: ctrl.illegal = 1'b1;
`endif
            default: ctrl = '0;
        endcase
    end

    assign imem.imem_req = ctrl.imem_req;
    assign RegWrite      = ctrl.reg_write;
    assign ALUctrl       = ctrl.alu_ctrl;
    assign ALUsrc        = ctrl.alu_src;
    assign ImmSrc        = ctrl.imm_src;
    assign PCsrc         = ctrl.pc_src;
    assign pc_en         = ctrl.pc_en;
    assign illegal       = ctrl.illegal;

    // ADDI retires in WB; BNE and the NOP path retire in EXEC.
    assign retire_evt = (state == S_WB) || ((state == S_EXEC) && !is_addi);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir         <= '0;
            retire_cnt <= '0;
        end else begin
            if ((state == S_FETCH) && imem.imem_ack) ir <= imem.instr_rdata;
            if (retire_evt) retire_cnt <= retire_cnt + {{(XLEN-1){1'b0}}, 1'b1};
        end
    end

endmodule
